// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and encodings for the pipeline hazard controller
package hazard_pkg;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;
    localparam logic [1:0] WB_LOAD = 2'b00;

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - per-operand forwarding select, MEM result preferred over WB
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rsE,
    input  logic [4:0] rdM,
    input  logic       regwriteM,
    input  logic [4:0] rdW,
    input  logic       regwriteW,
    output logic [1:0] fwdSel
);

    always_comb begin
        fwdSel = FWD_RF;
        if (regwriteM && (rdM != 5'd0) && (rdM == rsE)) begin
            fwdSel = FWD_M;
        end else if (regwriteW && (rdW != 5'd0) && (rdW == rsE)) begin
            fwdSel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/forward sequencing for the 5-stage RV32I pipeline
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned INIT_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs1D,
    input  logic [4:0]  rs2D,
    input  logic [4:0]  rs1E,
    input  logic [4:0]  rs2E,
    input  logic [4:0]  rdE,
    input  logic        regwriteE,
    input  logic [1:0]  wbselE,
    input  logic        pcselE,
    input  logic [4:0]  rdM,
    input  logic        regwriteM,
    input  logic [4:0]  rdW,
    input  logic        regwriteW,
    input  logic        dmem_reqM,
    input  logic        dmem_ready,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic        stallM,
    output logic        flushD,
    output logic        flushE,
    output logic        flushW,
    output logic        pcsel_gated,
    output logic [1:0]  forwardAE,
    output logic [1:0]  forwardBE,
    output logic        mem_timeout,
    output logic [15:0] stall_cnt
);

    localparam logic [3:0] INIT_LAST   = 4'(INIT_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_t     state;
    logic [3:0] initCnt;
    logic [7:0] waitCnt;

    logic [1:0] fwdA;
    logic [1:0] fwdB;
    logic       timeoutHit;
    logic       memStall;
    logic       redirect;
    logic       loadUse;

    fwd_sel u_fwd_a (
        .rsE       (rs1E),
        .rdM       (rdM),
        .regwriteM (regwriteM),
        .rdW       (rdW),
        .regwriteW (regwriteW),
        .fwdSel    (fwdA)
    );

    fwd_sel u_fwd_b (
        .rsE       (rs2E),
        .rdM       (rdM),
        .regwriteM (regwriteM),
        .rdW       (rdW),
        .regwriteW (regwriteW),
        .fwdSel    (fwdB)
    );

    // A timed-out access behaves like a completed one for that cycle, so a
    // pending redirect or load-use is still honoured on the release cycle.
    assign timeoutHit = (state == MEM_WAIT) && (waitCnt == TIMEOUT_CNT);

    always_comb begin
        memStall = 1'b0;
        if (state == RUN) begin
            memStall = dmem_reqM & ~dmem_ready;
        end else if (state == MEM_WAIT) begin
            memStall = ~dmem_ready & ~timeoutHit;
        end
    end

    assign redirect = (state != INIT) & pcselE & ~memStall;
    assign loadUse  = (state != INIT) & ~memStall & ~redirect
                    & regwriteE & (wbselE == WB_LOAD) & (rdE != 5'd0)
                    & ((rdE == rs1D) | (rdE == rs2D));

    always_comb begin
        stallF      = 1'b0;
        stallD      = 1'b0;
        stallE      = 1'b0;
        stallM      = 1'b0;
        flushD      = 1'b0;
        flushE      = 1'b0;
        flushW      = 1'b0;
        pcsel_gated = 1'b0;
        forwardAE   = FWD_RF;
        forwardBE   = FWD_RF;
        if (state == INIT) begin
            stallF = 1'b1;
            flushD = 1'b1;
            flushE = 1'b1;
        end else begin
            forwardAE = fwdA;
            forwardBE = fwdB;
            if (memStall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushW = 1'b1;
            end else if (redirect) begin
                flushD      = 1'b1;
                flushE      = 1'b1;
                pcsel_gated = 1'b1;
            end else if (loadUse) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= INIT;
            initCnt     <= 4'd0;
            waitCnt     <= 8'd0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    if (initCnt == INIT_LAST) begin
                        initCnt <= 4'd0;
                        state   <= RUN;
                    end else begin
                        initCnt <= initCnt + 4'd1;
                    end
                end
                RUN: begin
                    if (dmem_reqM && !dmem_ready) begin
                        waitCnt <= 8'd0;
                        state   <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state <= RUN;
                    end else if (timeoutHit) begin
                        mem_timeout <= 1'b1;
                        state       <= RUN;
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 16'd0;
        end else if (stallF && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic        regwriteE, pcselE, regwriteM, regwriteW, dmem_reqM, dmem_ready;
    logic [1:0]  wbselE;
    logic        stallF, stallD, stallE, stallM, flushD, flushE, flushW, pcsel_gated;
    logic [1:0]  forwardAE, forwardBE;
    logic        mem_timeout;
    logic [15:0] stall_cnt;

    int errCnt = 0;
    int chkCnt = 0;

    // {stallF,stallD,stallE,stallM,flushD,flushE,flushW,pcsel_gated,forwardAE,forwardBE}
    typedef logic [11:0] vec_t;
    localparam vec_t E_IDLE = 12'b0000_0000_0000;
    localparam vec_t E_INIT = 12'b1000_1100_0000;
    localparam vec_t E_LU   = 12'b1100_0100_0000;
    localparam vec_t E_MEM  = 12'b1111_0010_0000;
    localparam vec_t E_RED  = 12'b0000_1101_0000;

    vec_t expQ[$];

    hazard_ctrl #(.INIT_CYCLES(2), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .regwriteE(regwriteE), .wbselE(wbselE), .pcselE(pcselE),
        .rdM(rdM), .regwriteM(regwriteM), .rdW(rdW), .regwriteW(regwriteW),
        .dmem_reqM(dmem_reqM), .dmem_ready(dmem_ready),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushW(flushW),
        .pcsel_gated(pcsel_gated), .forwardAE(forwardAE), .forwardBE(forwardBE),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    function automatic vec_t withFwd(vec_t base, logic [1:0] fa, logic [1:0] fb);
        return {base[11:4], fa, fb};
    endfunction

    function automatic vec_t observed();
        return {stallF, stallD, stallE, stallM, flushD, flushE, flushW,
                pcsel_gated, forwardAE, forwardBE};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chkCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Expected vector is queued with the stimulus and retired at the next negedge.
    task automatic step(input string tag, input vec_t e);
        vec_t exp;
        expQ.push_back(e);
        @(negedge clk);
        exp = expQ.pop_front();
        check_val(tag, 32'(observed()), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
        regwriteE = 0; wbselE = 2'b11; pcselE = 0; regwriteM = 0; regwriteW = 0;
        dmem_reqM = 0; dmem_ready = 0;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step("rst_hold", E_INIT);
        check_val("rst_cnt", 32'(stall_cnt), 32'd0);
        check_val("rst_to", 32'(mem_timeout), 32'd0);

        rst_n = 1'b1;
        step("init0", E_INIT);
        step("init1", E_INIT);
        check_val("init_cnt", 32'(stall_cnt), 32'd2);
        step("run_idle", E_IDLE);

        // load-use on rs1, then the load has moved on
        regwriteE = 1; wbselE = 2'b00; rdE = 5; rs1D = 5;
        step("lu_rs1", E_LU);
        regwriteE = 0; rdE = 0;
        step("lu_clear", E_IDLE);
        regwriteE = 1; rdE = 9; rs1D = 1; rs2D = 9;
        step("lu_rs2", E_LU);
        rdE = 0; rs1D = 0; rs2D = 0;
        step("lu_x0", E_IDLE);
        rdE = 9; rs2D = 9; wbselE = 2'b01;
        step("lu_notload", E_IDLE);
        check_val("lu_cnt", 32'(stall_cnt), 32'd4);
        clear_inputs();

        // forwarding priorities
        rs1E = 3; rdM = 3; rdW = 3; regwriteM = 1; regwriteW = 1;
        step("fwd_m", withFwd(E_IDLE, 2'b10, 2'b00));
        regwriteM = 0;
        step("fwd_w", withFwd(E_IDLE, 2'b01, 2'b00));
        regwriteM = 1; rdW = 7; rs2E = 7;
        step("fwd_mw", withFwd(E_IDLE, 2'b10, 2'b01));
        rs1E = 0; rdM = 0; rs2E = 0; rdW = 0;
        step("fwd_x0", E_IDLE);
        clear_inputs();

        // redirect alone and overriding load-use
        pcselE = 1;
        step("redir", E_RED);
        regwriteE = 1; wbselE = 2'b00; rdE = 4; rs1D = 4;
        step("redir_lu", E_RED);
        clear_inputs();

        // memory wait with redirect held, forwarding still live
        dmem_reqM = 1; pcselE = 1; rs1E = 3; rdM = 3; regwriteM = 1;
        for (int i = 0; i < 4; i++) step("mw_stall", withFwd(E_MEM, 2'b10, 2'b00));
        dmem_ready = 1;
        step("mw_ready", withFwd(E_RED, 2'b10, 2'b00));
        clear_inputs();
        step("mw_after", E_IDLE);
        check_val("mw_cnt", 32'(stall_cnt), 32'd8);

        // timeout: detect cycle plus 15 wait cycles stalled, then release
        dmem_reqM = 1;
        for (int i = 0; i < 16; i++) step("to_stall", E_MEM);
        check_val("to_pre", 32'(mem_timeout), 32'd0);
        step("to_release", E_IDLE);
        dmem_reqM = 0;
        check_val("to_flag", 32'(mem_timeout), 32'd1);
        step("to_run", E_IDLE);
        step("to_run2", E_IDLE);
        check_val("to_sticky", 32'(mem_timeout), 32'd1);
        check_val("to_cnt", 32'(stall_cnt), 32'd24);

        // reset in the middle of a memory wait
        dmem_reqM = 1;
        step("mr_stall0", E_MEM);
        step("mr_stall1", E_MEM);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mr_out", 32'(observed()), 32'(E_INIT));
        check_val("mr_cnt", 32'(stall_cnt), 32'd0);
        check_val("mr_to", 32'(mem_timeout), 32'd0);
        @(posedge clk);
        #1;
        clear_inputs();
        rst_n = 1'b1;
        step("mr_init0", E_INIT);
        step("mr_init1", E_INIT);
        step("mr_run", E_IDLE);
        check_val("mr_cnt2", 32'(stall_cnt), 32'd2);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage RV32I core. Generates all stall, flush and forwarding selects for the IF/ID/EX/MEM/WB registers. Resolves load-use hazards, branch/jump redirects and multi-cycle data-memory waits. Runs a post-reset bubble-fill sequence and keeps a stall-cycle performance counter. Sits beside the datapath; it feeds `flushE` of the decode stage and the equivalent enables of every other stage register.

## Interface
- `INIT_CYCLES`, 2: bubble cycles forced after reset release (1..15).
- `MEM_TIMEOUT`, 15: max MEM_WAIT cycles before abandoning the access (1..255).
- `clk`  in  1  clock; every register updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rs1D`, `rs2D`  in  5 each  source registers of the instruction in ID.
- `rs1E`, `rs2E`, `rdE`  in  5 each  register fields in EX.
- `regwriteE`  in  1  EX instruction writes rd.
- `wbselE`  in  2  EX writeback select; `00` means a load.
- `pcselE`  in  1  a taken branch or jump is resolved in EX.
- `rdM`, `regwriteM`  in  5, 1  MEM destination and write enable.
- `rdW`, `regwriteW`  in  5, 1  WB destination and write enable.
- `dmem_reqM`  in  1  the MEM instruction accesses data memory.
- `dmem_ready`  in  1  data memory completes the access this cycle.
- `stallF`, `stallD`, `stallE`, `stallM`  out  1 each  hold the stage register.
- `flushD`, `flushE`, `flushW`  out  1 each  load a bubble into the stage register.
- `pcsel_gated`  out  1  redirect to the PC mux, equal to `pcselE & ~mem_stall`.
- `forwardAE`, `forwardBE`  out  2 each  operand selects: `00` register file, `01` WB result, `10` MEM ALU result.
- `mem_timeout`  out  1  sticky flag: an access was abandoned.
- `stall_cnt`  out  16  saturating count of cycles with `stallF`=1.

## Operation
- FSM has three states, INIT, RUN and MEM_WAIT. Reset puts it in INIT.
- **INIT:**
  - Outputs: `stallF`=1, `flushD`=1, `flushE`=1, `forwardAE`/`forwardBE`=00, `pcsel_gated`=0, all other stall/flush outputs 0.
  - A 4-bit counter runs from 0 to INIT_CYCLES-1, then the FSM goes to RUN.
- **RUN:** three conditions are evaluated combinationally.
  - **mem_stall** = `dmem_reqM & ~dmem_ready`.
    - Drives `stallF`, `stallD`, `stallE`, `stallM` and `flushW` to 1.
    - Forces `flushD`/`flushE` to 0.
    - Next state is MEM_WAIT.
  - **redirect** = `pcselE & ~mem_stall`.
    - Drives `flushD`=1, `flushE`=1 and `pcsel_gated`=1.
    - Overrides load-use: the ID instruction is wrong-path, so no stall.
  - **load_use** = `regwriteE & wbselE==00 & rdE!=0 & (rdE==rs1D | rdE==rs2D)`.
    - Drives `stallF`=1, `stallD`=1, `flushE`=1.
    - Applies only when neither mem_stall nor redirect is active.
  - Priority: mem_stall > redirect > load_use.
- **MEM_WAIT:**
  - Outputs are the same as mem_stall while `dmem_ready`=0.
  - A wait counter increments each cycle.
  - `dmem_ready`=1: all stalls drop that same cycle and the next state is RUN.
  - Counter reaches MEM_TIMEOUT with `dmem_ready`=0: set `mem_timeout`, release the stalls that cycle, next state RUN.
  - The wait counter is cleared on every entry to MEM_WAIT.
- **Forwarding** (RUN and MEM_WAIT, combinational, per operand):
  - `10` if `regwriteM & rdM!=0 & rdM==rsXE`.
  - Otherwise `01` if `regwriteW & rdW!=0 & rdW==rsXE`.
  - Otherwise `00`. MEM has priority over WB.
- **`stall_cnt`:** +1 on every edge where `stallF`=1, INIT included. Saturates at 16'hFFFF.
- **Reset** (asynchronous, at any time, including mid-MEM_WAIT):
  - State returns to INIT; both counters and `stall_cnt` go to 0; `mem_timeout` goes to 0.
  - Outputs take the INIT values immediately.

## Timing
- Every stall/flush/forward output is combinational from the inputs and the registered state. There is zero-cycle latency from hazard inputs to outputs.
- The first RUN cycle is cycle INIT_CYCLES after the rising edge that follows `rst_n` deassertion.
- A load-use stall lasts exactly 1 cycle: on the next edge the load moves to MEM and the condition clears.
- A redirect flushes exactly 1 cycle per assertion of `pcselE`.
- `pcselE` held during MEM_WAIT: the EX register is frozen, so the redirect takes effect in the cycle `dmem_ready` rises.

## Structure
- Shared package `hazard_pkg` holds:
  - state enum (INIT, RUN, MEM_WAIT);
  - forward encodings FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - WB_LOAD=2'b00.
- One sub-module, `fwd_sel`: inputs rsE, rdM, regwriteM, rdW, regwriteW; output the 2-bit select. It is instantiated twice, for operands A and B.

## Test plan
- **Reset, INIT_CYCLES=2:** `stallF`/`flushD`/`flushE`=1 for 2 cycles, then all 0; `stall_cnt`=2.
- **Load-use:** `wbselE`=00, `regwriteE`=1, `rdE`=5, `rs1D`=5 → one cycle of `stallF`=`stallD`=`flushE`=1. Same stimulus with `rdE`=0 → no stall.
- **Forwarding:** `rs1E`=3, `rdM`=3, `rdW`=3, both write enables =1 → `forwardAE`=10. With `regwriteM`=0 → `forwardAE`=01.
- **Memory wait with held redirect:** `dmem_reqM`=1, `dmem_ready` low for 4 cycles, `pcselE`=1 throughout → 4 cycles of all stalls + `flushW` with `pcsel_gated`=0; the cycle `dmem_ready` rises gives `flushD`=`flushE`=`pcsel_gated`=1.
- **Timeout:** `dmem_ready` held low, MEM_TIMEOUT=15 → `mem_timeout` goes high, the FSM returns to RUN, and the flag stays high until `rst_n` is pulsed.
- **Mid-wait reset:** `rst_n` pulsed low in MEM_WAIT → immediate INIT outputs and `stall_cnt`=0.
